// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART: FSM state encodings and baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc pulses in the last cycle before the count reaches zero.
// Load wins over counting; the counter parks at zero instead of wrapping.
module uart_bit_timer #(
    parameter int W = 9
) (
    input  logic         ipClk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge ipClk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART (start, DATA_BITS LSB first, optional parity, STOP_BITS).
// Define UART_PARITY_EN to insert/check a parity bit; otherwise opRxParityErr is tied low.
module uart_param import uart_pkg::*; #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 ipClk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] ipTxData,
    input  logic                 ipTxSend,
    output logic                 opTxBusy,
    output logic                 opTx,
    input  logic                 ipRx,
    output logic [DATA_BITS-1:0] opRxData,
    output logic                 opRxValid,
    output logic                 opRxFrameErr,
    output logic                 opRxParityErr
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int TW  = $clog2(CPB + 1);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] FULL_BIT = TW'(CPB);
    localparam logic [TW-1:0] HALF_BIT = TW'(CPB / 2);
    localparam logic          TWO_STOP = (STOP_BITS == 2);
`ifdef UART_PARITY_EN
    localparam logic          ODD      = (PARITY_ODD != 0);
`endif

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_ODD < 0 || PARITY_ODD > 1 || CPB < 2) begin : g_bad_cfg
            $error("uart_param: unsupported parameter combination");
        end
    endgenerate

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic                 tx_q, tx_d;
    logic                 tx_load, tx_tc;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    uart_bit_timer #(.W(TW)) u_tx_timer (
        .ipClk    (ipClk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (FULL_BIT),
        .tc       (tx_tc)
    );

    // tx_d is the line level for the next cycle, so opTx comes straight from a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (ipTxSend) begin
                    tx_state_d = TX_START;
                    tx_shift_d = ipTxData;
                    tx_d       = 1'b0;
                    tx_load    = 1'b1;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^ipTxData) ^ ODD;
`endif
                end
            end
            TX_START: begin
                if (tx_tc) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_load    = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tc) begin
                    tx_load = 1'b1;
                    if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        tx_stop_d  = TWO_STOP;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + BW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_tc) begin
                    tx_state_d = TX_STOP;
                    tx_stop_d  = TWO_STOP;
                    tx_d       = 1'b1;
                    tx_load    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_tc) begin
                    if (tx_stop_q) begin
                        tx_stop_d = 1'b0;
                        tx_load   = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign opTx     = tx_q;
    assign opTxBusy = (tx_state_q != TX_IDLE);

    // ---------------- receiver ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic [1:0]           sync_q, sync_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_load, rx_tc, rx_s;
    logic [TW-1:0]        rx_load_val;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad_q, rx_par_bad_d;
    logic                 rx_perr_q, rx_perr_d;
`endif

    assign sync_d = {sync_q[0], ipRx};
    assign rx_s   = sync_q[1];

    uart_bit_timer #(.W(TW)) u_rx_timer (
        .ipClk    (ipClk),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tc       (rx_tc)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_ferr_d   = 1'b0;
        rx_load     = 1'b0;
        rx_load_val = FULL_BIT;
`ifdef UART_PARITY_EN
        rx_par_bad_d = rx_par_bad_q;
        rx_perr_d    = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d  = RX_START;
                    rx_load     = 1'b1;
                    rx_load_val = HALF_BIT;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (!rx_s) begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                        rx_load    = 1'b1;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_tc) begin
                    rx_par_bad_d = rx_s ^ (^rx_shift_q) ^ ODD;
                    rx_state_d   = RX_STOP;
                    rx_load      = 1'b1;
                end
            end
`endif
            RX_STOP: begin
                // Only the first stop bit is checked; a low line means break or stuck-low.
                if (rx_tc) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = !rx_s;
`ifdef UART_PARITY_EN
                    rx_perr_d  = rx_par_bad_q;
`endif
                    rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            sync_q     <= 2'b11;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
            rx_perr_q    <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            sync_q     <= sync_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= rx_par_bad_d;
            rx_perr_q    <= rx_perr_d;
`endif
        end
    end

    assign opRxData     = rx_data_q;
    assign opRxValid    = rx_valid_q;
    assign opRxFrameErr = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign opRxParityErr = rx_perr_q;
`else
    assign opRxParityErr = 1'b0;
`endif

endmodule
